// File: rtl/arm_core_pkg.sv
// arm_core_pkg: fetch FSM states and instruction-field constants shared by the fetch unit and controller
package arm_core_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE} fetch_state_e;
  localparam int OPFUNC_MSB = 31;
  localparam int OPFUNC_LSB = 20;
  localparam int INSTR_W = 32;
  localparam int PC_INC = 4;
  localparam logic [2:0] OP_BRANCH = 3'b101;
endpackage

// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf: one-entry prefetch buffer {data, addr, valid, drop}; only built with PREFETCH_EN
`ifdef PREFETCH_EN
module fetch_prefetch_buf
  import arm_core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               launch,
  input  logic [ADDR_W-1:0]  launch_addr,
  input  logic               rsp,
  input  logic               push,
  input  logic [INSTR_W-1:0] rsp_data,
  input  logic               pop,
  input  logic               flush,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  addr,
  output logic               pending
);
  logic drop;
  // a flush with a prefetch still in flight marks it so its response is discarded on arrival
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid   <= 1'b0;
      drop    <= 1'b0;
      pending <= 1'b0;
      data    <= '0;
      addr    <= '0;
    end else begin
      pending <= launch ? 1'b1 : rsp ? 1'b0 : pending;
      addr    <= launch ? launch_addr : addr;
      valid   <= (push && !drop) ? 1'b1 : (pop || flush) ? 1'b0 : valid;
      data    <= push ? rsp_data : data;
      drop    <= (flush && (launch || (pending && !rsp))) ? 1'b1 : rsp ? 1'b0 : drop;
    end
endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-owning req/wait/issue fetch FSM; PREFETCH_EN adds a one-entry prefetch of pc+4
module instr_fetch_unit
  import arm_core_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [11:0]        opfunc,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);
  fetch_state_e state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, issue_pc_n, req_addr, tgt, pc_inc;
  logic [INSTR_W-1:0] instr_n;
  logic req_valid;
  assign pc_inc = pc + ADDR_W'(PC_INC);
  assign tgt = branch_target & ~ADDR_W'(3);
  assign imem_req_valid = req_valid & rst_n;
  assign imem_req_addr = req_addr;
  assign issue_valid = state == S_ISSUE;
  assign opfunc = instr[OPFUNC_MSB:OPFUNC_LSB];
`ifdef PREFETCH_EN
  logic launch, pf_rsp, push, pop, flush, buf_valid, pf_pending;
  logic [INSTR_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_addr;
  assign pf_rsp = imem_rsp_valid & pf_pending;
  fetch_prefetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk(clk), .rst_n(rst_n), .launch(launch), .launch_addr(req_addr), .rsp(pf_rsp),
    .push(push), .rsp_data(imem_rsp_data), .pop(pop), .flush(flush),
    .valid(buf_valid), .data(buf_data), .addr(buf_addr), .pending(pf_pending)
  );
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    issue_pc_n = issue_pc;
    req_valid = 1'b0;
    req_addr = pc;
`ifdef PREFETCH_EN
    launch = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
`endif
    case (state)
      S_REQ: begin
`ifdef PREFETCH_EN
        req_valid = !pf_pending;
`else
        req_valid = 1'b1;
`endif
        state_n = (req_valid && imem_req_ready) ? S_WAIT : S_REQ;
      end
      S_WAIT: if (imem_rsp_valid) begin
        instr_n = imem_rsp_data;
        issue_pc_n = pc;
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef PREFETCH_EN
        req_valid = !buf_valid && !pf_pending;
        req_addr = pc_inc;
        launch = req_valid && imem_req_ready;
        push = pf_rsp && !issue_ready;
`endif
        if (issue_ready) begin
          pc_n = branch_taken ? tgt : pc_inc;
          state_n = S_REQ;
`ifdef PREFETCH_EN
          flush = branch_taken;
          // sequential flow: reuse the buffered or just-arriving word, else wait for the in-flight prefetch
          if (!branch_taken) begin
            if (buf_valid) begin
              pop = 1'b1;
              instr_n = buf_data;
              issue_pc_n = buf_addr;
              state_n = S_ISSUE;
            end else if (pf_rsp) begin
              instr_n = imem_rsp_data;
              issue_pc_n = pc_inc;
              state_n = S_ISSUE;
            end else if (pf_pending || launch) state_n = S_WAIT;
          end
`endif
        end
      end
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      instr    <= '0;
      issue_pc <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      instr    <= instr_n;
      issue_pc <= issue_pc_n;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decoder environment checked against a PC-sequence reference model
module tb_instr_fetch_unit;
  import arm_core_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef PREFETCH_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, instr, issue_pc, branch_target = '0;
  logic issue_valid, issue_ready = 1'b0, branch_taken = 1'b0;
  logic [11:0] opfunc;
  int n_assert = 0, n_fail = 0, n_issued = 0, pend_cnt = 0, lat_max = 1;
  logic [31:0] m_pc = RST_PC, pend_addr = '0, hold_addr = 32'hFFFF_FFFF, stall_addr = '0;
  bit pend = 0, auto_mem = 1, stall_prev = 0, last_acc = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .instr(instr), .opfunc(opfunc),
    .issue_pc(issue_pc), .branch_taken(branch_taken), .branch_target(branch_target)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'hE081_0002;
      32'h4: return 32'hE242_2001;
      32'h8: return 32'hEA00_0003;
      default: return {a[15:0] ^ 16'h5A3C, a[17:2]};
    endcase
  endfunction

  // one clock: monitor the reference model before the edge, then play the memory after it
  task automatic cycle();
    logic acc, hs, bt;
    logic [31:0] aa, bta, ew;
    acc = imem_req_valid && imem_req_ready;
    aa = imem_req_addr;
    hs = issue_valid && issue_ready;
    bt = branch_taken;
    bta = branch_target;
`ifndef PREFETCH_EN
    if (stall_prev) begin
      n_assert++;
      if (!imem_req_valid || imem_req_addr !== stall_addr) begin
        n_fail++;
        $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, stall_addr);
      end
    end
`endif
    stall_prev = imem_req_valid && !imem_req_ready;
    stall_addr = aa;
    if (hs) begin
      ew = mem_word(m_pc);
      n_assert++;
      if (issue_pc !== m_pc || instr !== ew || opfunc !== ew[31:20]) begin
        n_fail++;
        $display("FAIL issue: pc=%h instr=%h opfunc=%h, required pc=%h instr=%h opfunc=%h", issue_pc, instr, opfunc, m_pc, ew, ew[31:20]);
      end
      n_issued++;
      m_pc = bt ? (bta & ~32'd3) : m_pc + 32'd4;
    end
    if (acc) begin
      n_assert++;
      if (pend) begin
        n_fail++;
        $display("FAIL one_outstanding: new req %h while %h pending, required none pending", aa, pend_addr);
      end
`ifndef PREFETCH_EN
      n_assert++;
      if (aa !== m_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h, required %h", aa, m_pc);
      end
`endif
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend = 1;
      pend_addr = aa;
      pend_cnt = int'($urandom_range(0, lat_max));
    end
    if (pend && auto_mem && pend_addr !== hold_addr) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(pend_addr);
        pend = 0;
      end else pend_cnt--;
    end
  endtask

  task automatic wait_issue(input string tag);
    int k = 0;
    while (!issue_valid && k < 200) begin
      cycle();
      k++;
    end
    n_assert++;
    if (!issue_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: issue_valid=%b, required 1", tag, issue_valid);
    end
  endtask

  task automatic model_reset();
    pend = 0;
    imem_rsp_valid = 1'b0;
    m_pc = RST_PC;
    stall_prev = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert += 5;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue_valid: got %b, required 0", issue_valid); end
    if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h, required 0", instr); end
    if (opfunc !== 12'h0) begin n_fail++; $display("FAIL rst_opfunc: got %h, required 0", opfunc); end
    if (issue_pc !== RST_PC) begin n_fail++; $display("FAIL rst_issue_pc: got %h, required %h", issue_pc, RST_PC); end
    model_reset();
    rst_n = 1'b1;
    #1;
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    auto_mem = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_assert++;
      if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL no_issue_before_rsp: got %b, required 0", issue_valid); end
    end
    auto_mem = 1;
  endtask

  task automatic test_sequential();
    issue_ready = 1'b0;
    branch_taken = 1'b0;
    wait_issue("seq0");
    n_assert += 2;
    if (opfunc !== 12'hE08) begin n_fail++; $display("FAIL seq0_opfunc: got %h, required e08", opfunc); end
    if (issue_pc !== 32'h0) begin n_fail++; $display("FAIL seq0_pc: got %h, required 0", issue_pc); end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
    wait_issue("seq1");
    n_assert += 2;
    if (opfunc !== 12'hE24) begin n_fail++; $display("FAIL seq1_opfunc: got %h, required e24", opfunc); end
    if (issue_pc !== 32'h4) begin n_fail++; $display("FAIL seq1_pc: got %h, required 4", issue_pc); end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ci, cp;
    logic [11:0] co;
    wait_issue("bp");
    ci = instr;
    co = opfunc;
    cp = issue_pc;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_assert++;
      if (instr !== ci || opfunc !== co || issue_pc !== cp || issue_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: instr=%h opfunc=%h pc=%h valid=%b, required %h %h %h 1", instr, opfunc, issue_pc, issue_valid, ci, co, cp);
      end
`ifndef PREFETCH_EN
      n_assert++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== cp) begin
        n_fail++;
        $display("FAIL bp_no_req: valid=%b addr=%h, required valid=0 addr=%h", imem_req_valid, imem_req_addr, cp);
      end
`endif
    end
  endtask

  task automatic test_branch();
    int k = 0;
    n_assert += 2;
    if (instr !== 32'hEA00_0003) begin n_fail++; $display("FAIL br_instr: got %h, required ea000003", instr); end
    if (opfunc[7:5] !== OP_BRANCH) begin n_fail++; $display("FAIL br_class: got %b, required %b", opfunc[7:5], OP_BRANCH); end
    branch_taken = 1'b1;
    branch_target = 32'h1E;
    issue_ready = 1'b1;
    cycle();
    branch_taken = 1'b0;
    branch_target = $urandom;
    issue_ready = 1'b0;
    while (!imem_req_valid && k < 50) begin
      cycle();
      k++;
    end
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1C) begin
      n_fail++;
      $display("FAIL br_target_req: valid=%b addr=%h, required valid=1 addr=0000001c", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stray_rsp();
    logic [31:0] ci, cp;
    wait_issue("stray");
    ci = instr;
    cp = issue_pc;
    if (!pend && !imem_rsp_valid) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
    end
    cycle();
    cycle();
    n_assert++;
    if (instr !== ci || issue_pc !== cp || issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_rsp: instr=%h pc=%h valid=%b, required %h %h 1", instr, issue_pc, issue_valid, ci, cp);
    end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int k = 0;
    auto_mem = 0;
    last_acc = 0;
    while (!last_acc && k < 50) begin
      cycle();
      k++;
    end
    n_assert++;
    if (!last_acc || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_reach: accepted=%b issue_valid=%b, required 1 0", last_acc, issue_valid);
    end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (imem_req_valid !== 1'b0 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: req_valid=%b issue_valid=%b, required 0 0", imem_req_valid, issue_valid);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    auto_mem = 1;
    #1;
    n_assert++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_wait_req: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    wait_issue("rst_wait");
    n_assert++;
    if (issue_pc !== RST_PC || instr !== 32'hE081_0002) begin
      n_fail++;
      $display("FAIL rst_wait_issue: pc=%h instr=%h, required %h e0810002", issue_pc, instr, RST_PC);
    end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
  endtask

  task automatic test_wrap();
    wait_issue("wrap_a");
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    issue_ready = 1'b1;
    cycle();
    branch_taken = 1'b0;
    issue_ready = 1'b0;
    wait_issue("wrap_b");
    n_assert++;
    if (issue_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h, required fffffffc", issue_pc); end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
    wait_issue("wrap_c");
    n_assert++;
    if (issue_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: got %h, required 00000000", issue_pc); end
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
  endtask

  task automatic test_throughput();
    int base, gap;
    lat_max = 0;
    issue_ready = 1'b1;
    branch_taken = 1'b0;
    imem_req_ready = 1'b1;
    base = n_issued;
    for (int k = 0; k < 50 && n_issued < base + 2; k++) cycle();
    for (int r = 0; r < 3; r++) begin
      gap = 0;
      base = n_issued;
      while (n_issued == base && gap < 50) begin
        cycle();
        gap++;
      end
      n_assert++;
      if (gap != EXP_GAP) begin n_fail++; $display("FAIL throughput: gap=%0d cycles, required %0d", gap, EXP_GAP); end
    end
    issue_ready = 1'b0;
    lat_max = 2;
  endtask

  task automatic test_random();
    int base = n_issued;
    for (int c = 0; c < 6000 && n_issued < base + 150; c++) begin
      issue_ready = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      cycle();
    end
    n_assert++;
    if (n_issued < base + 150) begin n_fail++; $display("FAIL random_progress: issued %0d, required 150", n_issued - base); end
    issue_ready = 1'b0;
    branch_taken = 1'b0;
    imem_req_ready = 1'b1;
  endtask

`ifdef PREFETCH_EN
  task automatic test_prefetch_drop();
    int k = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    issue_ready = 1'b0;
    lat_max = 0;
    hold_addr = 32'h8;
    wait_issue("pf0");
    issue_ready = 1'b1;
    cycle();
    issue_ready = 1'b0;
    wait_issue("pf4");
    while (!(pend && pend_addr == 32'h8) && k < 50) begin
      cycle();
      k++;
    end
    n_assert++;
    if (!(pend && pend_addr == 32'h8)) begin n_fail++; $display("FAIL pf_inflight: pend=%b addr=%h, required 1 00000008", pend, pend_addr); end
    branch_taken = 1'b1;
    branch_target = 32'h40;
    issue_ready = 1'b1;
    cycle();
    branch_taken = 1'b0;
    issue_ready = 1'b0;
    hold_addr = 32'hFFFF_FFFF;
    wait_issue("pf40");
    n_assert++;
    if (issue_pc !== 32'h40 || instr !== mem_word(32'h40)) begin
      n_fail++;
      $display("FAIL pf_drop: pc=%h instr=%h, required 00000040 %h", issue_pc, instr, mem_word(32'h40));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_stray_rsp();
    test_reset_in_wait();
    test_wrap();
    test_throughput();
    test_random();
`ifdef PREFETCH_EN
    test_prefetch_drop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
